// File: rtl/audio_pkg.sv
// audio_pkg: shared types, register map and helpers
// for the sfx_mixer sound-effect mixing path.
package audio_pkg;

  typedef enum logic [2:0] {
    IDLE,
    F0,
    F1,
    C1,
    MIX
  } mix_state_t;

  localparam logic [1:0] REG_V0_START = 2'd0;
  localparam logic [1:0] REG_V0_LEN   = 2'd1;
  localparam logic [1:0] REG_V1_START = 2'd2;
  localparam logic [1:0] REG_V1_LEN   = 2'd3;

  function automatic logic [15:0] sat16(
    input logic signed [17:0] s
  );
    logic [15:0] r;
    if (s > 18'sd32767)
      r = 16'h7fff;
    else if (s < -18'sd32768)
      r = 16'h8000;
    else
      r = s[15:0];
    return r;
  endfunction

endpackage

// File: rtl/sfx_voice.sv
// sfx_voice: one voice's start/ptr/remaining/active state.
// Ports: start_we/trig_we host loads, adv step -> ptr, active, done.
module sfx_voice #(
  parameter int ROM_AW = 15
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start_we,
  input  logic              trig_we,
  input  logic [15:0]       wdata,
  input  logic              adv,
  output logic [ROM_AW-1:0] ptr,
  output logic              active,
  output logic              done
);

  logic [ROM_AW-1:0] start;
  logic [15:0]       remaining;

  // A trigger write always wins over the step.
  assign done = adv && active && !trig_we &&
                (remaining == 16'd1);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      start     <= '0;
      ptr       <= '0;
      remaining <= '0;
      active    <= 1'b0;
    end else begin
      if (start_we)
        start <= wdata[ROM_AW-1:0];
      if (trig_we) begin
        ptr       <= start;
        remaining <= wdata;
        active    <= (wdata != 16'd0);
      end else if (adv && active) begin
        ptr       <= ptr + ROM_AW'(1);
        remaining <= remaining - 16'd1;
        if (remaining == 16'd1)
          active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sfx_mixer.sv
// sfx_mixer: two-voice ROM sample mixer onto the background stream.
// Ports: codec req/bg in, host reg writes, ROM addr/q, mix out, irq.
module sfx_mixer
  import audio_pkg::*;
#(
  parameter int ROM_AW = 15,
  parameter int DW     = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              sample_req,
  input  logic [DW-1:0]     bg_sample,
  input  logic              chipselect,
  input  logic              write,
  input  logic [1:0]        address,
  input  logic [15:0]       writedata,
  output logic              irq,
  output logic [ROM_AW-1:0] sfx_addr,
  input  logic [DW-1:0]     sfx_q,
  output logic [DW-1:0]     mix_out,
  output logic              mix_valid
);

  mix_state_t state, state_nxt;

  logic [DW-1:0]     bg_r, v0_r, v1_r;
  logic              wr, in_seq, is_mix;
  logic [1:0]        st_we, tr_we;
  logic [1:0]        adv, active, done, hold;
  logic [ROM_AW-1:0] ptr0, ptr1;
  logic signed [DW+1:0] sum;

  assign wr       = chipselect & write;
  assign st_we[0] = wr && (address == REG_V0_START);
  assign tr_we[0] = wr && (address == REG_V0_LEN);
  assign st_we[1] = wr && (address == REG_V1_START);
  assign tr_we[1] = wr && (address == REG_V1_LEN);

  assign is_mix = (state == MIX);
  assign in_seq = (state == F0) || (state == F1) ||
                  (state == C1);

  // A voice retriggered mid-sequence keeps its fresh
  // ptr/remaining: the step for that sample is skipped.
  assign adv[0] = is_mix && !hold[0] && !tr_we[0];
  assign adv[1] = is_mix && !hold[1] && !tr_we[1];

  sfx_voice #(.ROM_AW(ROM_AW)) u_v0 (
    .clk      (clk),
    .resetn   (resetn),
    .start_we (st_we[0]),
    .trig_we  (tr_we[0]),
    .wdata    (writedata),
    .adv      (adv[0]),
    .ptr      (ptr0),
    .active   (active[0]),
    .done     (done[0])
  );

  sfx_voice #(.ROM_AW(ROM_AW)) u_v1 (
    .clk      (clk),
    .resetn   (resetn),
    .start_we (st_we[1]),
    .trig_we  (tr_we[1]),
    .wdata    (writedata),
    .adv      (adv[1]),
    .ptr      (ptr1),
    .active   (active[1]),
    .done     (done[1])
  );

  always_comb begin
    sum = {{2{bg_r[DW-1]}}, bg_r};
    if (active[0])
      sum = sum + {{2{v0_r[DW-1]}}, v0_r};
    if (active[1])
      sum = sum + {{2{v1_r[DW-1]}}, v1_r};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (sample_req) state_nxt = F0;
      F0:      state_nxt = F1;
      F1:      state_nxt = C1;
      C1:      state_nxt = MIX;
      MIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bg_r      <= '0;
      v0_r      <= '0;
      v1_r      <= '0;
      sfx_addr  <= '0;
      mix_out   <= '0;
      mix_valid <= 1'b0;
      irq       <= 1'b0;
      hold      <= '0;
    end else begin
      mix_valid <= 1'b0;
      if (state == IDLE && sample_req) begin
        bg_r     <= bg_sample;
        sfx_addr <= ptr0;
      end
      if (state == F0)
        sfx_addr <= ptr1;
      if (state == F1)
        v0_r <= sfx_q;
      if (state == C1)
        v1_r <= sfx_q;
      if (is_mix) begin
        mix_out   <= sat16(sum);
        mix_valid <= 1'b1;
      end
      for (int v = 0; v < 2; v++) begin
        if (is_mix)
          hold[v] <= 1'b0;
        else if (tr_we[v] && in_seq)
          hold[v] <= 1'b1;
      end
      if (|done)
        irq <= 1'b1;
      else if (wr)
        irq <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sfx_mixer.sv
// tb_sfx_mixer: randomized + directed bench for sfx_mixer
// against a voice-level reference model and a ROM array.
module tb_sfx_mixer;

  logic        clk = 1'b0;
  logic        resetn;
  logic        sample_req;
  logic [15:0] bg_sample;
  logic        chipselect, write;
  logic [1:0]  address;
  logic [15:0] writedata;
  logic        irq;
  logic [14:0] sfx_addr;
  logic [15:0] sfx_q;
  logic [15:0] mix_out;
  logic        mix_valid;

  logic [15:0] rom [0:32767];

  int total = 0;
  int bad   = 0;

  logic [14:0] mstart [2];
  logic [14:0] mptr   [2];
  logic [15:0] mrem   [2];
  bit          mact   [2];
  bit          mirq;

  always #5 clk = ~clk;

  always @(posedge clk) sfx_q <= rom[sfx_addr];

  sfx_mixer dut (
    .clk        (clk),
    .resetn     (resetn),
    .sample_req (sample_req),
    .bg_sample  (bg_sample),
    .chipselect (chipselect),
    .write      (write),
    .address    (address),
    .writedata  (writedata),
    .irq        (irq),
    .sfx_addr   (sfx_addr),
    .sfx_q      (sfx_q),
    .mix_out    (mix_out),
    .mix_valid  (mix_valid)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic mreset();
    for (int v = 0; v < 2; v++) begin
      mstart[v] = '0;
      mptr[v]   = '0;
      mrem[v]   = '0;
      mact[v]   = 1'b0;
    end
    mirq = 1'b0;
  endtask

  task automatic mwrite(input logic [1:0] a,
                        input logic [15:0] d);
    int v;
    v = a[1];
    if (a[0] == 1'b0) begin
      mstart[v] = d[14:0];
    end else begin
      mptr[v] = mstart[v];
      mrem[v] = d;
      mact[v] = (d != 16'd0);
    end
    mirq = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a,
                    input logic [15:0] d);
    chipselect = 1'b1;
    write      = 1'b1;
    address    = a;
    writedata  = d;
    @(posedge clk); #1;
    chipselect = 1'b0;
    write      = 1'b0;
    mwrite(a, d);
  endtask

  // mid: 0 none, 1 host write at cycle 2, 2 stray req at cycle 2
  task automatic run_sample(input logic [15:0] bg,
                            input int mid,
                            input logic [1:0] ma,
                            input logic [15:0] md,
                            output logic [15:0] got);
    logic [15:0] f0, f1, exp;
    bit wm [2];
    int n, s;
    bit seen;
    f0 = rom[mptr[0]];
    f1 = rom[mptr[1]];
    wm[0] = 1'b0;
    wm[1] = 1'b0;
    bg_sample  = bg;
    sample_req = 1'b1;
    @(posedge clk); #1;
    sample_req = 1'b0;
    chk("addr_v0", sfx_addr, mptr[0]);
    n = 1;
    seen = 1'b0;
    while (!seen && n < 12) begin
      @(posedge clk); #1;
      n++;
      if (n == 2) begin
        chk("addr_v1", sfx_addr, mptr[1]);
        if (mid == 1) begin
          chipselect = 1'b1;
          write      = 1'b1;
          address    = ma;
          writedata  = md;
          mwrite(ma, md);
          if (ma[0]) wm[ma[1]] = 1'b1;
        end
        if (mid == 2) sample_req = 1'b1;
      end
      if (n == 3) begin
        chipselect = 1'b0;
        write      = 1'b0;
        sample_req = 1'b0;
      end
      if (mix_valid) seen = 1'b1;
    end
    chk("latency", n, 5);
    s = int'($signed(bg));
    if (mact[0]) s = s + int'($signed(f0));
    if (mact[1]) s = s + int'($signed(f1));
    if (s > 32767)       exp = 16'h7fff;
    else if (s < -32768) exp = 16'h8000;
    else                 exp = s[15:0];
    got = mix_out;
    chk("mix", mix_out, exp);
    for (int v = 0; v < 2; v++) begin
      if (mact[v] && !wm[v]) begin
        mptr[v] = mptr[v] + 15'd1;
        mrem[v] = mrem[v] - 16'd1;
        if (mrem[v] == 16'd0) begin
          mact[v] = 1'b0;
          mirq    = 1'b1;
        end
      end
    end
    chk("irq", irq, mirq);
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (mix_valid) seen = 1'b1;
    end
    chk("one_pulse", seen, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] got;
    logic [1:0]  a;
    logic [15:0] d;
    int          mid;
    resetn     = 1'b0;
    sample_req = 1'b0;
    bg_sample  = '0;
    chipselect = 1'b0;
    write      = 1'b0;
    address    = '0;
    writedata  = '0;
    for (int i = 0; i < 32768; i++)
      rom[i] = 16'($urandom);
    mreset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mix", mix_out, 0);
    chk("rst_valid", mix_valid, 0);
    chk("rst_addr", sfx_addr, 0);
    chk("rst_irq", irq, 0);
    resetn = 1'b1;
    @(posedge clk); #1;

    rom[16'h100] = 16'd10;
    rom[16'h101] = 16'd20;
    rom[16'h102] = 16'd30;
    wr(2'd0, 16'h0100);
    wr(2'd1, 16'd3);
    run_sample(16'd1000, 0, 0, 0, got);
    chk("sv_1", got, 1010);
    run_sample(16'd1000, 0, 0, 0, got);
    chk("sv_2", got, 1020);
    run_sample(16'd1000, 0, 0, 0, got);
    chk("sv_3", got, 1030);
    chk("sv_irq", irq, 1);
    run_sample(16'd1000, 0, 0, 0, got);
    chk("sv_4", got, 1000);
    wr(2'd0, 16'h0100);
    chk("irq_clr", irq, 0);

    rom[16'h50] = 16'h0011;
    wr(2'd2, 16'h0050);
    wr(2'd3, 16'd4);
    run_sample(16'h0123, 0, 0, 0, got);
    bg_sample  = 16'h0200;
    sample_req = 1'b1;
    @(posedge clk); #1;
    sample_req = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b0;
    #1;
    chk("mid_rst_mix", mix_out, 0);
    chk("mid_rst_valid", mix_valid, 0);
    chk("mid_rst_addr", sfx_addr, 0);
    chk("mid_rst_irq", irq, 0);
    mreset();
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    run_sample(16'h0100, 0, 0, 0, got);
    chk("post_rst", got, 16'h0100);

    rom[16'h300] = 16'h7000;
    wr(2'd0, 16'h0300);
    wr(2'd1, 16'd1);
    run_sample(16'h7000, 0, 0, 0, got);
    chk("sat_hi", got, 16'h7fff);
    rom[16'h301] = 16'h9000;
    rom[16'h400] = 16'h9000;
    wr(2'd0, 16'h0301);
    wr(2'd1, 16'd1);
    wr(2'd2, 16'h0400);
    wr(2'd3, 16'd1);
    run_sample(16'h9000, 0, 0, 0, got);
    chk("sat_lo", got, 16'h8000);

    rom[16'h500] = 16'd5;
    rom[16'h600] = 16'hfffd;
    wr(2'd0, 16'h0500);
    wr(2'd1, 16'd1);
    wr(2'd2, 16'h0600);
    wr(2'd3, 16'd1);
    run_sample(16'd0, 0, 0, 0, got);
    chk("two_voice", got, 16'd2);

    rom[16'h700] = 16'd7;
    rom[16'h200] = 16'h0022;
    wr(2'd0, 16'h0700);
    wr(2'd1, 16'd5);
    run_sample(16'd0, 0, 0, 0, got);
    chk("retrig_a", got, 16'd7);
    wr(2'd0, 16'h0200);
    wr(2'd1, 16'd2);
    run_sample(16'd0, 0, 0, 0, got);
    chk("retrig_b", got, 16'h0022);
    wr(2'd1, 16'd0);
    run_sample(16'h0040, 0, 0, 0, got);
    chk("zero_len", got, 16'h0040);
    chk("zero_irq", irq, 0);

    wr(2'd1, 16'd3);
    run_sample(16'd0, 1, 2'd1, 16'd0, got);
    chk("inflight_off", got, 16'd0);
    wr(2'd1, 16'd2);
    run_sample(16'd5, 2, 0, 0, got);
    chk("busy", got, 16'h0027);

    rom[16'h7fff] = 16'd1;
    rom[16'h0000] = 16'd2;
    wr(2'd0, 16'h7fff);
    wr(2'd1, 16'd2);
    run_sample(16'd0, 0, 0, 0, got);
    chk("wrap_a", got, 16'd1);
    run_sample(16'd0, 0, 0, 0, got);
    chk("wrap_b", got, 16'd2);

    for (int it = 0; it < 40; it++) begin
      repeat ($urandom_range(0, 3)) begin
        a = 2'($urandom_range(0, 3));
        if (a[0]) d = 16'($urandom_range(0, 4));
        else      d = 16'($urandom);
        wr(a, d);
      end
      mid = $urandom_range(0, 5);
      if (mid > 2) mid = 0;
      a = {1'($urandom_range(0, 1)), 1'b1};
      d = 16'($urandom_range(0, 4));
      run_sample(16'($urandom), mid, a, d, got);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
